// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the TX byte FIFO, the drain scheduler and the UART shift engine.
// master = scheduler side, slave = FIFO/transmitter side.
interface uart_tx_sched_if #(
    parameter int D_W = 8
);
    logic           fifo_empty;
    logic [D_W-1:0] fifo_data;
    logic           fifo_rd_en;
    logic           tx_busy;
    logic           tx_start;
    logic [D_W-1:0] tx_data;

    modport master (
        input  fifo_empty, fifo_data, tx_busy,
        output fifo_rd_en, tx_start, tx_data
    );

    modport slave (
        output fifo_empty, fifo_data, tx_busy,
        input  fifo_rd_en, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Drains the TX FIFO into the UART transmitter one frame at a time, with an optional
// idle gap after each frame and a flush path that discards queued bytes.
module uart_tx_sched #(
    parameter int D_W        = 8,
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    uart_tx_sched_if.master      bus,
    output logic [CNT_W-1:0]     sent_cnt,
    output logic                 active
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_FLUSH
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [D_W-1:0]   tx_data_q, tx_data_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_data_q  <= '0;
            sent_cnt_q <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            sent_cnt_q <= sent_cnt_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        sent_cnt_d = sent_cnt_q;
        gap_d      = gap_q;
        unique case (state_q)
            S_IDLE: begin
                gap_d = '0;
                // Flush wins over en so a pending discard never lets a stale byte out.
                if (flush && !bus.fifo_empty) begin
                    state_d = S_FLUSH;
                end else if (en && !bus.fifo_empty && !bus.tx_busy) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH:     state_d = S_LATCH;
            S_LATCH: begin
                tx_data_d = bus.fifo_data;
                state_d   = S_START;
            end
            S_START:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (bus.tx_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    sent_cnt_d = sent_cnt_q + CNT_W'(1);
                    gap_d      = '0;
                    state_d    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_FLUSH:     if (bus.fifo_empty || !flush) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Flush pops are gated by fifo_empty so an empty FIFO is never read.
    assign bus.fifo_rd_en = (state_q == S_FETCH) || ((state_q == S_FLUSH) && !bus.fifo_empty);
    assign bus.tx_start   = (state_q == S_START);
    assign bus.tx_data    = tx_data_q;
    assign sent_cnt       = sent_cnt_q;
    assign active         = (state_q != S_IDLE);
endmodule
